// File: rtl/intersection_controller.sv
`default_nettype none
// ============================================================================
// Module   : intersection_controller
// Purpose  : Phase sequencer for a two-road intersection. Drives north-south
//            and east-west red/yellow/green lamps plus a pedestrian walk lamp.
//            NS green is held until there is demand (east-west car or a
//            latched pedestrian request); pedestrian requests are latched and
//            served from the all-red clearance phase.
// Ports    : Clock       - system clock, rising-edge active
//            Reset       - asynchronous, active-high
//            EwCar       - level, vehicle waiting on the east-west road
//            PedRequest  - pedestrian button, sampled every rising edge
//            NsRed/NsYellow/NsGreen, EwRed/EwYellow/EwGreen - lamp outputs
//            Walk        - pedestrian walk lamp
//            PedPending  - request latched and not yet served
//            Phase       - current state encoding (debug)
// Revision : 1.0 - initial release
// ============================================================================
module intersection_controller #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4,
    parameter int CW           = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       EwCar,
    input  logic       PedRequest,
    output logic       NsRed,
    output logic       NsYellow,
    output logic       NsGreen,
    output logic       EwRed,
    output logic       EwYellow,
    output logic       EwGreen,
    output logic       Walk,
    output logic       PedPending,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_e;

    // Last count value of each phase: a phase of N cycles exits when cnt==N-1.
    localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_TICKS - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TICKS - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TICKS - 1);
    localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_TICKS - 1);

    // Held as a raw 3-bit vector so the unused codes 6/7 are representable
    // and recover through the default branch.
    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          dir_ew;        // 1: next green after all-red is east-west
    logic          dir_ew_next;
    logic          ped_pending;
    logic          ped_pending_next;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= NS_GREEN;
            cnt         <= '0;
            dir_ew      <= 1'b1;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            dir_ew      <= dir_ew_next;
            ped_pending <= ped_pending_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + 1'b1;
        dir_ew_next = dir_ew;
        // Requests seen while walking are dropped; all others are latched,
        // including one arriving on the all-red exit edge.
        ped_pending_next = (ped_pending | PedRequest) & (state != PED_WALK);

        case (state)
            NS_GREEN: begin
                if (cnt == GREEN_LAST) begin
                    // Saturate while waiting for demand.
                    cnt_next = cnt;
                    if (EwCar || ped_pending) begin
                        state_next = NS_YELLOW;
                        cnt_next   = '0;
                    end
                end
            end
            NS_YELLOW: begin
                if (cnt == YELLOW_LAST) begin
                    state_next  = ALL_RED;
                    dir_ew_next = 1'b1;
                    cnt_next    = '0;
                end
            end
            ALL_RED: begin
                if (cnt == ALLRED_LAST) begin
                    if (ped_pending)
                        state_next = PED_WALK;
                    else
                        state_next = dir_ew ? EW_GREEN : NS_GREEN;
                    cnt_next = '0;
                end
            end
            EW_GREEN: begin
                if (cnt == GREEN_LAST) begin
                    state_next = EW_YELLOW;
                    cnt_next   = '0;
                end
            end
            EW_YELLOW: begin
                if (cnt == YELLOW_LAST) begin
                    state_next  = ALL_RED;
                    dir_ew_next = 1'b0;
                    cnt_next    = '0;
                end
            end
            PED_WALK: begin
                if (cnt == WALK_LAST) begin
                    state_next = dir_ew ? EW_GREEN : NS_GREEN;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = NS_GREEN;
                cnt_next   = '0;
            end
        endcase
    end

    // Moore decode from the state register only.
    always_comb begin
        NsRed    = 1'b0;
        NsYellow = 1'b0;
        NsGreen  = 1'b0;
        EwRed    = 1'b0;
        EwYellow = 1'b0;
        EwGreen  = 1'b0;
        Walk     = 1'b0;
        case (state)
            NS_GREEN:  begin NsGreen  = 1'b1; EwRed = 1'b1; end
            NS_YELLOW: begin NsYellow = 1'b1; EwRed = 1'b1; end
            EW_GREEN:  begin EwGreen  = 1'b1; NsRed = 1'b1; end
            EW_YELLOW: begin EwYellow = 1'b1; NsRed = 1'b1; end
            PED_WALK:  begin NsRed = 1'b1; EwRed = 1'b1; Walk = 1'b1; end
            // ALL_RED and the unreachable codes show red on both roads.
            default:   begin NsRed = 1'b1; EwRed = 1'b1; end
        endcase
    end

    assign PedPending = ped_pending;
    assign Phase      = state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_controller
// Purpose  : Self-checking bench for intersection_controller. Stimulus pushes
//            hand-computed expected phase / pending values into a queue; a
//            monitor pops one entry per sample point and compares lamps,
//            walk, pending and phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_controller;

    logic       Clock;
    logic       Reset;
    logic       EwCar;
    logic       PedRequest;
    logic       NsRed, NsYellow, NsGreen;
    logic       EwRed, EwYellow, EwGreen;
    logic       Walk;
    logic       PedPending;
    logic [2:0] Phase;

    intersection_controller #(
        .GREEN_TICKS (8),
        .YELLOW_TICKS(2),
        .ALLRED_TICKS(1),
        .WALK_TICKS  (4),
        .CW          (4)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .EwCar     (EwCar),
        .PedRequest(PedRequest),
        .NsRed     (NsRed),
        .NsYellow  (NsYellow),
        .NsGreen   (NsGreen),
        .EwRed     (EwRed),
        .EwYellow  (EwYellow),
        .EwGreen   (EwGreen),
        .Walk      (Walk),
        .PedPending(PedPending),
        .Phase     (Phase)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic [2:0] ph;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    event chk_ev;

    // Expected lamps {NsR,NsY,NsG,EwR,EwY,EwG} per phase.
    function automatic logic [5:0] lamps_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp_v);
        end
    endtask

    // Monitor: one queue entry per negedge, or per asynchronous check event.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock or chk_ev);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("phase", int'(Phase), int'(e.ph));
                check("ped_pending", int'(PedPending), int'(e.pend));
                check("walk", int'(Walk), (e.ph == 3'd5) ? 1 : 0);
                if (e.ph <= 3'd5) begin
                    check("lamps", int'({NsRed, NsYellow, NsGreen, EwRed, EwYellow, EwGreen}),
                          int'(lamps_for(e.ph)));
                    check("ns_onehot", $countones({NsRed, NsYellow, NsGreen}), 1);
                    check("ew_onehot", $countones({EwRed, EwYellow, EwGreen}), 1);
                end
            end
        end
    end

    // Drive inputs for the next edge, then record what that edge must produce.
    task automatic cyc(input logic ew, input logic pr, input logic [2:0] ph, input logic pend);
        exp_t e;
        EwCar      = ew;
        PedRequest = pr;
        @(posedge Clock);
        #1;
        e.ph   = ph;
        e.pend = pend;
        q.push_back(e);
    endtask

    // Check now, with no clock edge in between.
    task automatic async_check(input logic [2:0] ph, input logic pend);
        exp_t e;
        e.ph   = ph;
        e.pend = pend;
        q.push_back(e);
        -> chk_ev;
    endtask

    task automatic wait_mid();
        @(negedge Clock);
        #1;
    endtask

    initial begin
        Reset      = 1'b1;
        EwCar      = 1'b0;
        PedRequest = 1'b0;

        // Reset held, then idle with no demand: NS green forever.
        repeat (2) cyc(0, 0, 3'd0, 0);
        Reset = 1'b0;
        repeat (50) cyc(0, 0, 3'd0, 0);

        // Fixed cycle, two 22-cycle periods (NS green already saturated).
        repeat (2) begin
            repeat (2) cyc(1, 0, 3'd1, 0);
            cyc(1, 0, 3'd2, 0);
            repeat (8) cyc(1, 0, 3'd3, 0);
            repeat (2) cyc(1, 0, 3'd4, 0);
            cyc(1, 0, 3'd2, 0);
            repeat (8) cyc(1, 0, 3'd0, 0);
        end

        // Demand arrival: yellow on the edge that first samples EwCar=1.
        repeat (12) cyc(0, 0, 3'd0, 0);
        repeat (2) cyc(1, 0, 3'd1, 0);
        cyc(1, 0, 3'd2, 0);
        repeat (3) cyc(1, 0, 3'd3, 0);

        // Asynchronous reset mid EW green.
        wait_mid();
        Reset = 1'b1;
        #1;
        async_check(3'd0, 0);
        cyc(0, 0, 3'd0, 0);
        Reset = 1'b0;                       // cycle 0: NS green, cnt 0

        // Pedestrian request during NS green (sampled at edge 4).
        repeat (3) cyc(0, 0, 3'd0, 0);      // cycles 1-3
        cyc(0, 1, 3'd0, 1);                 // 4
        repeat (3) cyc(0, 0, 3'd0, 1);      // 5-7
        repeat (2) cyc(0, 0, 3'd1, 1);      // 8-9
        cyc(0, 0, 3'd2, 1);                 // 10
        cyc(0, 0, 3'd5, 1);                 // 11: first walk cycle
        repeat (3) cyc(0, 0, 3'd5, 0);      // 12-14
        repeat (8) cyc(0, 0, 3'd3, 0);      // 15-22
        repeat (2) cyc(0, 0, 3'd4, 0);      // 23-24
        cyc(0, 0, 3'd2, 0);                 // 25
        cyc(0, 0, 3'd0, 0);                 // 26

        // Request held through the whole walk is discarded.
        cyc(0, 1, 3'd0, 1);                 // 27
        repeat (6) cyc(0, 0, 3'd0, 1);      // 28-33
        repeat (2) cyc(0, 0, 3'd1, 1);      // 34-35
        cyc(0, 0, 3'd2, 1);                 // 36
        cyc(0, 0, 3'd5, 1);                 // 37
        repeat (3) cyc(0, 1, 3'd5, 0);      // 38-40
        cyc(0, 1, 3'd3, 0);                 // 41
        repeat (7) cyc(0, 0, 3'd3, 0);      // 42-48
        repeat (2) cyc(0, 0, 3'd4, 0);      // 49-50
        cyc(0, 0, 3'd2, 0);                 // 51
        cyc(0, 0, 3'd0, 0);                 // 52: straight to NS green

        // Request latched on the all-red exit edge: served at next all-red.
        repeat (7) cyc(1, 0, 3'd0, 0);      // 53-59
        repeat (2) cyc(1, 0, 3'd1, 0);      // 60-61
        cyc(1, 0, 3'd2, 0);                 // 62
        cyc(1, 1, 3'd3, 1);                 // 63
        repeat (7) cyc(1, 0, 3'd3, 1);      // 64-70
        repeat (2) cyc(1, 0, 3'd4, 1);      // 71-72
        cyc(1, 0, 3'd2, 1);                 // 73
        cyc(0, 0, 3'd5, 1);                 // 74
        repeat (3) cyc(0, 0, 3'd5, 0);      // 75-77
        cyc(0, 0, 3'd0, 0);                 // 78: dir was NS

        // Illegal encodings recover to NS green on the next edge.
        wait_mid();
        force dut.state = 3'd6;
        #1;
        release dut.state;
        async_check(3'd6, 0);
        cyc(0, 0, 3'd0, 0);
        wait_mid();
        force dut.state = 3'd7;
        #1;
        release dut.state;
        async_check(3'd7, 0);
        cyc(0, 0, 3'd0, 0);

        // Reset drops a pending request immediately.
        cyc(0, 1, 3'd0, 1);
        wait_mid();
        Reset = 1'b1;
        #1;
        async_check(3'd0, 0);
        cyc(0, 0, 3'd0, 0);
        Reset = 1'b0;
        cyc(0, 0, 3'd0, 0);

        // Drain: the monitor must have consumed every expectation.
        wait_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/intersection_controller.md
# intersection_controller

Sequencing controller for a two-road intersection: it drives a north-south and an east-west red/yellow/green light set plus a pedestrian walk signal from one phase state machine. It adds a demand-driven green extension and a latched pedestrian request to the basic fixed-cycle light. It sits above the per-lamp outputs and is the single owner of phase timing.

## Interface

Parameters:
- GREEN_TICKS, 8, minimum green duration in cycles; EW green is exactly this long.
- YELLOW_TICKS, 2, yellow duration in cycles.
- ALLRED_TICKS, 1, all-red clearance duration in cycles.
- WALK_TICKS, 4, pedestrian walk duration in cycles.
- CW, 4, phase counter width; 2^CW must be at least the largest *_TICKS value.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- EwCar  input  1  level; a vehicle is waiting on the east-west road.
- PedRequest  input  1  pedestrian button; sampled every rising edge.
- NsRed, NsYellow, NsGreen  output  1 each  north-south lamps.
- EwRed, EwYellow, EwGreen  output  1 each  east-west lamps.
- Walk  output  1  pedestrian walk lamp.
- PedPending  output  1  a request is latched and not yet served.
- Phase  output  3  current state encoding, for debug.

## Operation

- States and encodings: NS_GREEN=0, NS_YELLOW=1, ALL_RED=2, EW_GREEN=3, EW_YELLOW=4, PED_WALK=5. Encodings 6 and 7 are illegal and go to NS_GREEN on the next edge.
- Outputs are Moore, decoded from the state register only:
  - NS_GREEN: NsGreen=1, EwRed=1.
  - NS_YELLOW: NsYellow=1, EwRed=1.
  - EW_GREEN: EwGreen=1, NsRed=1.
  - EW_YELLOW: EwYellow=1, NsRed=1.
  - ALL_RED and PED_WALK: NsRed=1, EwRed=1.
  - Walk=1 only in PED_WALK.
  - In every state exactly one lamp per road is lit.
- Counter `cnt` clears to 0 on every state change and increments once per cycle in a state. A state of duration N exits on the edge where cnt==N-1.
- NS_GREEN is demand-extended:
  - It exits to NS_YELLOW only when cnt==GREEN_TICKS-1 and (EwCar or PedPending).
  - While waiting, cnt saturates at GREEN_TICKS-1.
- Fixed-duration exits:
  - NS_YELLOW goes to ALL_RED and sets dir=EW.
  - EW_GREEN goes to EW_YELLOW; it is never extended.
  - EW_YELLOW goes to ALL_RED and sets dir=NS.
- ALL_RED exit, at the end of ALL_RED:
  - If PedPending=1, go to PED_WALK.
  - Otherwise go to EW_GREEN when dir=EW, or NS_GREEN when dir=NS.
- PED_WALK runs WALK_TICKS cycles, then goes to the green selected by dir.
- Pedestrian latch: PedPending_next = (PedPending | PedRequest) & (state != PED_WALK).
  - A request arriving during PED_WALK is discarded.
  - A request in any other state, including the ALL_RED exit cycle, is latched. If it is latched on the ALL_RED exit edge, the next ALL_RED serves it.

## Timing

- Reset asserted: state=NS_GREEN, cnt=0, dir=EW, PedPending=0. Outputs immediately show NsGreen=1, EwRed=1, all others 0, Phase=0. No clock edge is needed.
- Reset asserted mid-phase, including during PED_WALK: the same values apply immediately and any pending request is lost.
- On the first edge after Reset deasserts, cnt goes 0 to 1.
- Free-running cycle with EwCar=1 and no requests, in cycles: NS_GREEN 8, NS_YELLOW 2, ALL_RED 1, EW_GREEN 8, EW_YELLOW 2, ALL_RED 1. Period is 22 cycles.
- A pedestrian service adds ALL_RED + WALK_TICKS after the yellow that follows the request, giving 5 red-red cycles at the defaults.
- PedRequest to PedPending=1: one edge. PedPending clears on the first edge inside PED_WALK.
- No output glitches: outputs change only after rising edges or on Reset assertion.

## Test plan

- Reset and idle:
  - Stimulus: assert Reset mid-EW_GREEN. Outputs must switch to NsGreen=1, EwRed=1 without a clock edge.
  - Stimulus: release Reset with EwCar=0, no requests, for 50 cycles. The block must stay in NS_GREEN (Phase=0) throughout.
- Fixed cycle: EwCar=1 constantly. Phase must follow 0(8),1(2),2(1),3(8),4(2),2(1) and repeat every 22 cycles. Lamp one-hot per road holds in every cycle.
- Demand arrival: EwCar=0 until cycle 20, then EwCar=1. NsYellow must rise on the edge after EwCar is first sampled high.
- Pedestrian in NS green: pulse PedRequest for 1 cycle at cycle 3 with EwCar=0. Required sequence:
  - PedPending=1 from cycle 4.
  - NS_GREEN ends at cycle 8.
  - Then NS_YELLOW for 2 cycles, ALL_RED for 1, and Walk=1 for 4 cycles with both roads red.
  - Then EW_GREEN.
- Request during walk: hold PedRequest=1 throughout PED_WALK. PedPending must stay 0 and the next ALL_RED must go straight to NS_GREEN.
- Illegal state: force Phase to 6 or 7. The block must be in NS_GREEN after the next edge.
